// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register index width, the r0 constant and the
// write-back record type consumed by the write-back stage and forwarding unit.
package pipeline_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] reg_idx;
        logic [DATA_W-1:0]    data;
    } wb_rec_t;

endpackage

// File: rtl/regfile_array.sv
// Architectural register storage: one synchronous write port, two
// combinational read ports, r0 hardwired to zero, synchronous clear on Rst.
module regfile_array #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              writeEn,
    input  logic [4:0]        writeIdx,
    input  logic [DATA_W-1:0] writeData,
    input  logic [4:0]        readIdx1,
    input  logic [4:0]        readIdx2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);
    import pipeline_pkg::REG_ZERO;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Reset clears every entry and wins over a write in the same cycle;
    // writes aimed at r0 are dropped so the entry stays zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn && (writeIdx != REG_ZERO)) begin
            regs[writeIdx] <= writeData;
        end
    end

    assign readData1 = (readIdx1 == REG_ZERO) ? '0 : regs[readIdx1];
    assign readData2 = (readIdx2 == REG_ZERO) ? '0 : regs[readIdx2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus register file: selects and qualifies the write, keeps a
// one-cycle write-back record and a retirement counter. Option: WB_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              regWrite_in,
    input  logic [DATA_W-1:0] dataMem_in,
    input  logic [DATA_W-1:0] ALUoutput_in,
    input  logic [4:0]        writeReg_in,
    input  logic              NoWrite_in,
    input  logic              MemRead_in,
    input  logic              stall_in,
    input  logic [4:0]        readReg1,
    input  logic [4:0]        readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [DATA_W-1:0] wbData_out,
    output logic [4:0]        wbReg_out,
    output logic              wbValid_out,
    output logic [CNT_W-1:0]  retire_count
);
    import pipeline_pkg::REG_ZERO;

    logic [DATA_W-1:0] wdata;
    logic              retire;
    logic              we;
    logic [DATA_W-1:0] arrData1;
    logic [DATA_W-1:0] arrData2;

    // A retirement is any unsuppressed write request, r0 included; only
    // nonzero destinations actually reach the array.
    assign wdata  = MemRead_in ? dataMem_in : ALUoutput_in;
    assign retire = regWrite_in & ~NoWrite_in & ~stall_in;
    assign we     = retire & (writeReg_in != REG_ZERO);

    regfile_array #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) uArray (
        .Clk       (Clk),
        .Rst       (Rst),
        .writeEn   (we),
        .writeIdx  (writeReg_in),
        .writeData (wdata),
        .readIdx1  (readReg1),
        .readIdx2  (readReg2),
        .readData1 (arrData1),
        .readData2 (arrData2)
    );

`ifdef WB_BYPASS_EN
    // we already excludes r0, so the bypass can never leak a value onto r0.
    assign readData1 = (we && (readReg1 == writeReg_in)) ? wdata : arrData1;
    assign readData2 = (we && (readReg2 == writeReg_in)) ? wdata : arrData2;
`else
    assign readData1 = arrData1;
    assign readData2 = arrData2;
`endif

    // Record and counter share the reset; the counter wraps freely.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wbValid_out  <= 1'b0;
            wbReg_out    <= REG_ZERO;
            wbData_out   <= '0;
            retire_count <= '0;
        end else begin
            wbValid_out <= we;
            wbReg_out   <= we ? writeReg_in : REG_ZERO;
            wbData_out  <= we ? wdata : '0;
            if (retire) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps from the test plan plus
// randomized traffic, all compared against a behavioural register-file model.
module tb_wb_regfile;

    localparam int CW = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        regWrite_in;
    logic [31:0] dataMem_in;
    logic [31:0] ALUoutput_in;
    logic [4:0]  writeReg_in;
    logic        NoWrite_in;
    logic        MemRead_in;
    logic        stall_in;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] wbData_out;
    logic [4:0]  wbReg_out;
    logic        wbValid_out;
    logic [CW-1:0] retire_count;

    wb_regfile #(.DATA_W(32), .NUM_REGS(32), .CNT_W(CW)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .regWrite_in  (regWrite_in),
        .dataMem_in   (dataMem_in),
        .ALUoutput_in (ALUoutput_in),
        .writeReg_in  (writeReg_in),
        .NoWrite_in   (NoWrite_in),
        .MemRead_in   (MemRead_in),
        .stall_in     (stall_in),
        .readReg1     (readReg1),
        .readReg2     (readReg2),
        .readData1    (readData1),
        .readData2    (readData2),
        .wbData_out   (wbData_out),
        .wbReg_out    (wbReg_out),
        .wbValid_out  (wbValid_out),
        .retire_count (retire_count)
    );

    always #5 Clk = ~Clk;

    logic [31:0] model [32];
    int          modelCount;
    logic        expValid;
    logic [4:0]  expReg;
    logic [31:0] expData;
    int          total = 0;
    int          bad   = 0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] selData();
        return MemRead_in ? dataMem_in : ALUoutput_in;
    endfunction

    function automatic logic modelWrites();
        return regWrite_in && !NoWrite_in && !stall_in && (writeReg_in != 5'd0);
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (modelWrites() && idx == writeReg_in) return selData();
`endif
        return model[idx];
    endfunction

    task automatic checkOutput();
        checkValue("readData1", readData1, expRead(readReg1));
        checkValue("readData2", readData2, expRead(readReg2));
        checkValue("wbValid", {31'd0, wbValid_out}, {31'd0, expValid});
        checkValue("wbReg", {27'd0, wbReg_out}, {27'd0, expReg});
        checkValue("wbData", wbData_out, expData);
        checkValue("retireCount", {28'd0, retire_count}, 32'(modelCount % 16));
    endtask

    // What the clock edge does to the architectural state, from the rules.
    task automatic updateModel();
        if (Rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            expValid   = 1'b0;
            expReg     = 5'd0;
            expData    = 32'd0;
            modelCount = 0;
        end else begin
            expValid = modelWrites();
            expReg   = expValid ? writeReg_in : 5'd0;
            expData  = expValid ? selData() : 32'd0;
            if (expValid) model[writeReg_in] = selData();
            if (regWrite_in && !NoWrite_in && !stall_in) modelCount = (modelCount + 1) % 16;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rw, input logic mr,
                                 input logic [31:0] dm, input logic [31:0] alu,
                                 input logic [4:0] wr, input logic nw, input logic st,
                                 input logic [4:0] r1, input logic [4:0] r2);
        Rst = rst; regWrite_in = rw; MemRead_in = mr; dataMem_in = dm;
        ALUoutput_in = alu; writeReg_in = wr; NoWrite_in = nw; stall_in = st;
        readReg1 = r1; readReg2 = r2;
        #1;
    endtask

    task automatic stepCycle();
        @(negedge Clk);
        checkOutput();
        @(posedge Clk);
        updateModel();
        #1;
    endtask

    task automatic idleReads(input logic [4:0] r1, input logic [4:0] r2);
        regWrite_in = 1'b0; Rst = 1'b0; readReg1 = r1; readReg2 = r2;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'hX;
        modelCount = 0; expValid = 1'b0; expReg = 5'd0; expData = 32'd0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge Clk); updateModel(); #1;
        @(posedge Clk); updateModel(); #1;

        // Reset state across every index.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            checkValue("resetRead1", readData1, 32'd0);
            stepCycle();
        end
        checkValue("resetCount", {28'd0, retire_count}, 32'd0);
        checkValue("resetValid", {31'd0, wbValid_out}, 32'd0);

        applyStimulus(0, 1, 0, 0, 32'hDEADBEEF, 5'd5, 0, 0, 0, 0);
        stepCycle();
        idleReads(5'd5, 5'd0);
        checkValue("r5Read", readData1, 32'hDEADBEEF);
        checkValue("r5Valid", {31'd0, wbValid_out}, 32'd1);
        checkValue("r5Reg", {27'd0, wbReg_out}, 32'd5);
        checkValue("r5Count", {28'd0, retire_count}, 32'd1);
        stepCycle();

        applyStimulus(0, 1, 1, 32'h0000_1234, 32'hFFFF_FFFF, 5'd7, 0, 0, 0, 0);
        stepCycle();
        idleReads(5'd7, 5'd0);
        checkValue("r7Load", readData1, 32'h0000_1234);
        stepCycle();

        applyStimulus(0, 1, 1, 32'h5555, 32'hFFFF_FFFF, 5'd7, 0, 1, 0, 0);
        stepCycle();
        idleReads(5'd7, 5'd0);
        checkValue("r7Stall", readData1, 32'h0000_1234);
        checkValue("stallCount", {28'd0, retire_count}, 32'd2);
        stepCycle();

        applyStimulus(0, 1, 1, 32'h5555, 32'hFFFF_FFFF, 5'd7, 1, 0, 0, 0);
        stepCycle();
        idleReads(5'd7, 5'd0);
        checkValue("r7NoWrite", readData1, 32'h0000_1234);
        checkValue("noWriteCount", {28'd0, retire_count}, 32'd2);
        stepCycle();

        applyStimulus(0, 1, 0, 0, 32'hABCD, 5'd0, 0, 0, 0, 0);
        stepCycle();
        idleReads(5'd0, 5'd0);
        checkValue("r0Read", readData1, 32'd0);
        checkValue("r0Valid", {31'd0, wbValid_out}, 32'd0);
        checkValue("r0Count", {28'd0, retire_count}, 32'd3);
        stepCycle();

        applyStimulus(0, 1, 0, 0, 32'h11, 5'd9, 0, 0, 0, 5'd9);
`ifdef WB_BYPASS_EN
        checkValue("r9SameCycle", readData2, 32'h11);
`else
        checkValue("r9SameCycle", readData2, 32'd0);
`endif
        stepCycle();
        idleReads(5'd0, 5'd9);
        checkValue("r9NextCycle", readData2, 32'h11);
        stepCycle();

        // Count is 4 here; eleven commits bring it to 15, one more wraps.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(0, 1, 0, 0, 32'(i + 100), 5'(i + 10), 0, 0, 5'(i + 10), 5'd9);
            stepCycle();
        end
        idleReads(5'd0, 5'd0);
        checkValue("countAt15", {28'd0, retire_count}, 32'd15);
        applyStimulus(0, 1, 0, 0, 32'h42, 5'd21, 0, 0, 0, 0);
        stepCycle();
        idleReads(5'd0, 5'd0);
        checkValue("countWrap", {28'd0, retire_count}, 32'd0);

        applyStimulus(1, 1, 0, 0, 32'h77, 5'd3, 0, 0, 5'd3, 5'd5);
        stepCycle();
        idleReads(5'd3, 5'd5);
        checkValue("rstR3", readData1, 32'd0);
        checkValue("rstR5", readData2, 32'd0);
        checkValue("rstValid", {31'd0, wbValid_out}, 32'd0);
        checkValue("rstReg", {27'd0, wbReg_out}, 32'd0);
        checkValue("rstData", wbData_out, 32'd0);
        checkValue("rstCount", {28'd0, retire_count}, 32'd0);
        stepCycle();

        for (int n = 0; n < 500; n++) begin
            logic [4:0] wr;
            wr = 5'($urandom_range(0, 31));
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          $urandom, $urandom, wr,
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)));
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
